// File: rtl/p_buf_ctrl_pkg.sv
// Shared definitions for the frame buffer controller: FSM encoding and default geometry.
package p_buf_ctrl_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int RAM_WIDTH_DEF     = 8;
  localparam int RAM_ADDR_BITS_DEF = 4;

endpackage

// File: rtl/p_buf_ctrl_ram_p.sv
// Distributed RAM: synchronous write, asynchronous (zero-latency) read.
module RAM_P #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] write_address,
  input  logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_ADDR_BITS-1:0] read_addr,
  output logic [RAM_WIDTH-1:0]     output_data
);

  localparam int DEPTH = 2 ** RAM_ADDR_BITS;

  logic [RAM_WIDTH-1:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem_q[write_address] <= input_data;
    end
  end

  assign output_data = mem_q[read_addr];

endmodule

// File: rtl/p_buf_ctrl.sv
// Store-and-forward frame buffer: loads one frame (up to DEPTH words) then drains it.
module p_buf_ctrl
  import p_buf_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RAM_WIDTH-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [RAM_WIDTH-1:0]   m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [RAM_ADDR_BITS:0] frame_len
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [RAM_ADDR_BITS:0]   frame_len_q, frame_len_d;
  logic                     wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // A full buffer closes the frame even without s_last.
          if (s_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d     = DRAIN;
            frame_len_d = {1'b0, wr_ptr_q} + 1'b1;
          end
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = (({1'b0, rd_ptr_q} + 1'b1) == frame_len_q);
        if (m_ready) begin
          if (m_last) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign busy      = (state_q == DRAIN);
  assign frame_len = frame_len_q;

  // Reset cycle must never commit a write into the buffer.
  RAM_P #(
    .RAM_WIDTH    (RAM_WIDTH),
    .RAM_ADDR_BITS(RAM_ADDR_BITS)
  ) u_ram (
    .clk          (clk),
    .write_enable (wr_en && !reset),
    .write_address(wr_ptr_q),
    .input_data   (s_data),
    .read_addr    (rd_ptr_q),
    .output_data  (m_data)
  );

endmodule

// File: tb/tb_p_buf_ctrl.sv
// Scoreboard bench for p_buf_ctrl: frame-level reference model plus directed and random stimulus.
module tb_p_buf_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_ready, busy;
  logic [4:0] frame_len;

  p_buf_ctrl dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; } wd_t;

  wd_t exp_q[$];
  wd_t cur_q[$];
  wd_t w;
  int  total = 0, bad = 0;
  int  exp_len = 0;
  int  acc_cnt = 0, pop_cnt = 0, cyc_n = 0;
  int  mode = 0;
  bit  m_drain = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a frame is a list of accepted words; it closes on s_last or at 16 words,
  // then is emitted in order with the last flag on its final word.
  always @(negedge clk) begin
    bit was_drain;
    was_drain = m_drain;
    chk("s_ready", s_ready, !was_drain);
    chk("m_valid", m_valid, was_drain);
    chk("busy", busy, was_drain);
    chk("frame_len", frame_len, exp_len);
    if (was_drain) begin
      if (exp_q.size() == 0) chk("underflow", 1, 0);
      else begin
        chk("m_data", m_data, exp_q[0].d);
        chk("m_last", m_last, exp_q[0].l);
        if (m_ready) begin
          w = exp_q.pop_front();
          pop_cnt++;
          if (w.l) m_drain = 0;
        end
      end
    end else begin
      chk("m_last_idle", m_last, 0);
    end
    if (reset) begin
      exp_q.delete();
      cur_q.delete();
      m_drain = 0;
      exp_len = 0;
    end else if (!was_drain && s_valid) begin
      cur_q.push_back('{s_data, s_last});
      acc_cnt++;
      if (s_last || cur_q.size() == 16) begin
        for (int i = 0; i < cur_q.size(); i++) begin
          w   = cur_q[i];
          w.l = (i == cur_q.size() - 1);
          exp_q.push_back(w);
        end
        exp_len = cur_q.size();
        m_drain = 1;
        cur_q.delete();
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc_n % 3 == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n0;
    int k;
    n0 = acc_cnt;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (k = 0; k < 100; k++) begin
      cyc();
      if (acc_cnt != n0) break;
    end
    if (k == 100) chk("send_timeout", 1, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      if (!m_drain) break;
      cyc();
    end
    if (k == 300) chk("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    int p0;
    int k;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    cyc();
    do_reset();

    // Full 16-word frame
    for (int i = 0; i < 16; i++) send(8'(i), i == 15);
    wait_idle();
    // Short frame
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 1);
    wait_idle();
    // Backpressure
    mode = 1;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), i == 3);
    wait_idle();
    mode = 0;
    // Overlong: 20 words, the tail becomes the next frame
    for (int i = 0; i < 20; i++) send(8'h30 + 8'(i), 0);
    send(8'h44, 1);
    wait_idle();
    // Single word
    send(8'h5A, 1);
    wait_idle();
    // Reset mid-drain after two words out
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), i == 7);
    p0 = pop_cnt;
    for (k = 0; k < 50 && (pop_cnt - p0) < 2; k++) cyc();
    if (k == 50) chk("mid_drain_timeout", 1, 0);
    do_reset();
    send(8'h11, 0); send(8'h22, 1);
    wait_idle();

    // Random traffic with occasional reset
    mode = 2;
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 5) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    mode = 0;
    cyc();
    wait_idle();
    chk("exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p_buf_ctrl.md
P_BUF_CTRL -- requirements
Module: p_buf_ctrl

Interface
REQ-001 SHALL take parameter RAM_WIDTH, default 8: data word width in bits.
REQ-002 SHALL take parameter RAM_ADDR_BITS, default 4: buffer address width; DEPTH = 2**RAM_ADDR_BITS words (16).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port s_data  input  RAM_WIDTH: inbound word.
REQ-006 SHALL have port s_valid  input  1: inbound word present.
REQ-007 SHALL have port s_last  input  1: inbound word is the last of its frame.
REQ-008 SHALL have port s_ready  output  1: block accepts inbound word this cycle.
REQ-009 SHALL have port m_data  output  RAM_WIDTH: outbound word.
REQ-010 SHALL have port m_valid  output  1: outbound word present.
REQ-011 SHALL have port m_last  output  1: outbound word is the last of its frame.
REQ-012 SHALL have port m_ready  input  1: downstream accepts outbound word.
REQ-013 SHALL have port busy  output  1: high while in DRAIN.
REQ-014 SHALL have port frame_len  output  RAM_ADDR_BITS+1: word count of the frame currently held; range 1..DEPTH.

Function
REQ-015 SHALL implement a two-state FSM, LOAD and DRAIN; reset state LOAD.
REQ-016 In LOAD: s_ready=1, m_valid=0; on s_valid&&s_ready, write s_data to buffer[wr_ptr], then increment wr_ptr.
REQ-017 LOAD->DRAIN on an accepted word that has s_last=1 or that lands at wr_ptr=DEPTH-1, whichever comes first; frame_len latches wr_ptr+1 on that cycle.
REQ-018 A frame reaching DEPTH words without s_last SHALL be closed at DEPTH; the next inbound word starts a new frame.
REQ-019 In DRAIN: s_ready=0, m_valid=1, m_data=buffer[rd_ptr] read combinationally (zero-latency read).
REQ-020 On m_valid&&m_ready in DRAIN, increment rd_ptr; m_last=1 exactly when rd_ptr=frame_len-1.
REQ-021 DRAIN->LOAD on the transfer with m_last=1; wr_ptr and rd_ptr return to 0 on that edge.
REQ-022 First m_valid SHALL assert the cycle after the closing inbound word is accepted; one word per cycle while m_ready=1.
REQ-023 m_data, m_last and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 s_valid in DRAIN SHALL be ignored, with no write and no pointer change; m_ready in LOAD SHALL be ignored.
REQ-025 Pointers SHALL be RAM_ADDR_BITS wide; frame_len RAM_ADDR_BITS+1 wide so DEPTH=16 is representable; no pointer wrap within a frame.
REQ-026 busy SHALL equal (state==DRAIN); frame_len SHALL hold its value until the next frame closes.

Reset
REQ-027 On reset=1 at a clock edge: state=LOAD, wr_ptr=0, rd_ptr=0, frame_len=0, busy=0, m_valid=0, m_last=0; s_ready=1 from the first cycle after reset.
REQ-028 Reset mid-LOAD or mid-DRAIN SHALL abandon the frame; buffer contents are not cleared, and no write occurs in the reset cycle.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (LOAD=0, DRAIN=1) and the default RAM_WIDTH/RAM_ADDR_BITS constants.
REQ-030 The buffer SHALL be one instance of RAM_P (distributed RAM, synchronous write, asynchronous read), driven by the controller: write_enable=s_valid&&s_ready, write_address=wr_ptr, read_addr=rd_ptr.

Verification
REQ-031 Full frame: 16 words 0x00..0x0F, s_last on the 16th, m_ready=1 -> m_data 0x00..0x0F on 16 consecutive cycles, m_last on 0x0F, frame_len=16.
REQ-032 Short frame: 3 words 0xA1,0xA2,0xA3 with s_last on 0xA3 -> frame_len=3; outputs 0xA1,0xA2,0xA3, m_last on 0xA3; s_ready=1 the cycle after.
REQ-033 Backpressure: 4-word frame, m_ready toggles 1,0,0,1,... -> each word held stable while stalled; order 4 words, m_last only on the 4th.
REQ-034 Overlong: 20 words without s_last -> first frame is 16 words with m_last on word 16; words 17-20 load as the next frame after the drain.
REQ-035 Single word: 0x5A with s_last -> frame_len=1, m_valid the next cycle, m_last=1 on the same transfer.
REQ-036 Reset mid-DRAIN after 2 of 8 words out -> next cycle m_valid=0, s_ready=1; a new 2-word frame 0x11,0x22 outputs 0x11,0x22.
